turbo_rsc_vit_dec: RTL and testbench
====================================

// Module: turbo_rsc_vit_dec
// PURPOSE
//  Hard-decision Viterbi decoder for one RSC constituent code of the turbo encoder (feedback 1+D+D^2, feedforward 1+D^2, memory 2).
//  Accepts one (systematic, parity) symbol pair per handshake and decodes a trellis-terminated block of K_LEN information bits plus 2 tail steps.
//  Emits the decoded bits in forward order.
//  Serves as the receive-side check/decoder for the encoder path and as the baseline for later iterative decoding.
// PARAMETERS
//  K_LEN   16  information bits per block (>=4); block = K_LEN+2 trellis steps
//  MW      6   path-metric width in bits (>=5)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  in_valid   in   1  symbol pair present on in_sys/in_par
//  in_sys     in   1  received systematic bit (hard decision)
//  in_par     in   1  received parity bit (hard decision)
//  in_ready   out  1  decoder accepts a symbol this cycle
//  out_valid  out  1  out_bit is a decoded information bit
//  out_bit    out  1  decoded information bit, forward order
//  out_last   out  1  high with the K_LEN-th decoded bit
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; metrics PM[0]=0, PM[1..3]=16; counters 0.
//  Encoder model, state s={s1,s2}:
//   - a = u^s1^s2; p = a^s2; next state = {a,s1}.
//   - Tail steps force a=0 (u=s1^s2).
//  FSM states and transitions:
//   - IDLE: in_ready=1. First accepted symbol (in_valid&in_ready) runs step 0 and moves to ACS.
//   - ACS: in_ready=1. One add-compare-select per accepted symbol; in_valid=0 cycles stall without state change. After step K_LEN+1 is accepted -> TRACE.
//   - TRACE: in_ready=0. One step per cycle for K_LEN+2 cycles, from step K_LEN+1 down to 0, starting at state 0 (terminated trellis). Then -> OUT.
//   - OUT: in_ready=0. out_valid=1 for exactly K_LEN consecutive cycles, bits 0..K_LEN-1. No backpressure. out_last on the final bit. Then -> IDLE with metrics re-initialised.
//  ACS details:
//   - Branch metric = Hamming distance of (in_sys,in_par) to the expected (u,p); range 0..2.
//   - Each next state has 2 predecessors {s1,0} and {s1,1}.
//   - Pick the smaller candidate; on a tie pick the predecessor with s2=0.
//   - Store one decision bit per state per step in a (K_LEN+2)x4 memory.
//   - Normalisation: when all four new metrics have MSB=1, clear the MSB in all four the same cycle. Metrics never wrap.
//  Traceback at step t from next state {a,s1}:
//   - s2 = decision bit; predecessor = {s1,s2}; u = a^s1^s2.
//   - Write u to the bit buffer when t<K_LEN; tail bits are discarded.
//  Latency: first out_valid occurs K_LEN+3 cycles after the cycle the last tail symbol is accepted.
//  Boundaries:
//   - in_valid during TRACE/OUT is ignored; in_ready=0.
//   - Back-to-back blocks: the next block is accepted from the cycle after out_last.
//   - rst mid-block: immediate return to IDLE; partial block discarded; no out_valid.
//   - Symbols are never dropped or double-counted across stalls.
// TESTING
//  1. Block of 18 all-zero pairs -> 16 out bits all 0; out_last on the 16th; in_ready back to 1 the next cycle.
//  2. Info 1,0,0,...,0 with tail from the golden RSC model (first pairs (1,1),(0,1),(0,1),(0,0)) -> bit0=1, others 0.
//  3. Random 16-bit info word from the golden model with a single flipped parity bit at step 5 -> output equals the info word.
//  4. Same word with in_valid de-asserted every other cycle -> identical output; latency from the last symbol unchanged.
//  5. rst pulsed after 9 accepted symbols, then a full zero block -> no output from the aborted block; the clean block decodes to 16 zeros.
//  6. Two back-to-back blocks (0xA5C3, 0x0F0F); symbols held valid during TRACE/OUT -> in_ready=0 throughout; both words decoded in order.

Source files
------------

// File: rtl/turbo_rsc_vit_dec.sv
// Hard-decision Viterbi decoder for the memory-2 RSC constituent code (fb 1+D+D^2, ff 1+D^2).
// Decodes one terminated block of K_LEN info bits plus 2 tail steps and emits the bits in forward order.
module turbo_rsc_vit_dec #(
    parameter int K_LEN = 16,
    parameter int MW    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_sys,
    input  logic in_par,
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    output logic out_last,
    output logic busy
);
    localparam int NS = K_LEN + 2;
    localparam int SW = $clog2(NS);
    localparam int OW = $clog2(K_LEN);

    // Handshake: a symbol pair is consumed on every rising edge where in_valid && in_ready.
    typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;
    state_t state, state_nx;

    logic [MW-1:0] pm [4];
    logic [MW-1:0] pm_raw [4];
    logic [MW-1:0] pm_nx [4];
    logic [3:0]    dec_nx;
    logic [3:0]    dec_mem [NS];
    logic [SW-1:0] step;
    logic [1:0]    tb_st;
    logic [K_LEN-1:0] bit_buf;
    logic [OW-1:0] out_cnt;
    logic          accept;
    logic          tb_dec;
    logic          tb_u;
    logic          all_msb;

    assign in_ready  = !rst && (state == IDLE || state == ACS);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_bit   = out_valid && bit_buf[out_cnt];
    assign out_last  = out_valid && (out_cnt == OW'(K_LEN - 1));

    assign tb_dec = dec_mem[step][tb_st];
    assign tb_u   = tb_st[1] ^ tb_st[0] ^ tb_dec;

    // Next state {a,s1} has predecessors {s1,0} and {s1,1}; ties go to s2=0.
    always_comb begin
        logic       a;
        logic       s1;
        logic [1:0] bm0;
        logic [1:0] bm1;
        logic [MW-1:0] c0;
        logic [MW-1:0] c1;
        a   = 1'b0;
        s1  = 1'b0;
        bm0 = 2'd0;
        bm1 = 2'd0;
        c0  = '0;
        c1  = '0;
        dec_nx = 4'd0;
        for (int ns = 0; ns < 4; ns++) begin
            a   = ns[1];
            s1  = ns[0];
            bm0 = {1'b0, in_sys ^ a ^ s1} + {1'b0, in_par ^ a};
            bm1 = {1'b0, in_sys ^ a ^ s1 ^ 1'b1} + {1'b0, in_par ^ a ^ 1'b1};
            c0  = pm[{s1, 1'b0}] + MW'(bm0);
            c1  = pm[{s1, 1'b1}] + MW'(bm1);
            dec_nx[ns] = (c1 < c0);
            pm_raw[ns] = (c1 < c0) ? c1 : c0;
        end
        all_msb = pm_raw[0][MW-1] & pm_raw[1][MW-1] & pm_raw[2][MW-1] & pm_raw[3][MW-1];
        for (int ns = 0; ns < 4; ns++) begin
            pm_nx[ns] = pm_raw[ns];
            if (all_msb) pm_nx[ns][MW-1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACS;
            ACS:     if (accept && step == SW'(NS - 1)) state_nx = TRACE;
            TRACE:   if (step == '0) state_nx = OUT;
            OUT:     if (out_cnt == OW'(K_LEN - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) dec_mem[step] <= dec_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm[0]   <= '0;
            pm[1]   <= MW'(16);
            pm[2]   <= MW'(16);
            pm[3]   <= MW'(16);
            step    <= '0;
            tb_st   <= 2'd0;
            bit_buf <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                IDLE, ACS: begin
                    tb_st <= 2'd0;
                    if (accept) begin
                        for (int i = 0; i < 4; i++) pm[i] <= pm_nx[i];
                        if (step != SW'(NS - 1)) step <= step + 1'b1;
                    end
                end
                TRACE: begin
                    if (step < SW'(K_LEN)) bit_buf[step[OW-1:0]] <= tb_u;
                    tb_st <= {tb_st[0], tb_dec};
                    if (step != '0) step <= step - 1'b1;
                end
                OUT: begin
                    if (out_cnt == OW'(K_LEN - 1)) begin
                        out_cnt <= '0;
                        step    <= '0;
                        pm[0]   <= '0;
                        pm[1]   <= MW'(16);
                        pm[2]   <= MW'(16);
                        pm[3]   <= MW'(16);
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_turbo_rsc_vit_dec.sv
// Bench for turbo_rsc_vit_dec: golden RSC encoder drives blocks with at most one channel error,
// so the decoded word must equal the information word.
module tb_turbo_rsc_vit_dec;
    localparam int K  = 16;
    localparam int NS = K + 2;

    logic clk, rst, in_valid, in_sys, in_par;
    logic in_ready, out_valid, out_bit, out_last, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int bit_idx = 0;
    bit prev_last = 0;
    logic [0:0] exp_q[$];

    turbo_rsc_vit_dec #(.K_LEN(K), .MW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sys(in_sys), .in_par(in_par),
        .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit),
        .out_last(out_last), .busy(busy)
    );

    // clock / reset
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Golden encoder: a = u^s1^s2, p = a^s2, next = {a,s1}; tail forces a=0.
    function automatic void encode(input logic [K-1:0] info,
                                   output logic [NS-1:0] sys_v, output logic [NS-1:0] par_v);
        int s1, s2, u, a;
        s1 = 0; s2 = 0;
        sys_v = '0; par_v = '0;
        for (int t = 0; t < NS; t++) begin
            if (t < K) u = int'(info[t]);
            else       u = s1 ^ s2;
            a = u ^ s1 ^ s2;
            sys_v[t] = u[0];
            par_v[t] = a[0] ^ s2[0];
            s2 = s1;
            s1 = a;
        end
    endfunction

    // driver: gap_mode 0 = none, 1 = idle cycle before every symbol, 2 = random
    task automatic send_sym(input logic s, input logic p, input int gap_mode);
        int g;
        @(negedge clk);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 0;
            @(negedge clk);
        end
        in_valid = 1; in_sys = s; in_par = p;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=%0d required=<200", g);
        end
        last_acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic send_block(input logic [K-1:0] info, input int flip_step, input bit flip_par,
                              input int gap_mode, input bit expect_out);
        logic [NS-1:0] sv, pv;
        encode(info, sv, pv);
        if (flip_step >= 0) begin
            if (flip_par) pv[flip_step] = ~pv[flip_step];
            else          sv[flip_step] = ~sv[flip_step];
        end
        if (expect_out)
            for (int i = 0; i < K; i++) exp_q.push_back(info[i]);
        for (int t = 0; t < NS; t++) send_sym(sv[t], pv[t], gap_mode);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 0;
        while ((exp_q.size() != 0 || bit_idx != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_timeout", (g < 300) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // scoreboard / compare process
    always @(negedge clk) begin
        logic [0:0] e;
        if (rst) begin
            prev_last = 0;
        end else begin
            if (prev_last) chk("ready_after_last", int'(in_ready), 1);
            prev_last = 0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out actual=out_valid=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_bit[%0d]", bit_idx), int'(out_bit), int'(e));
                    chk($sformatf("out_last[%0d]", bit_idx), int'(out_last), (bit_idx == K - 1) ? 1 : 0);
                    chk("ready_low_in_out", int'(in_ready), 0);
                    if (bit_idx == 0) chk("latency", cyc - last_acc_cyc, K + 3);
                    bit_idx = (bit_idx == K - 1) ? 0 : bit_idx + 1;
                end
                prev_last = out_last;
            end
        end
    end

    initial begin
        logic [NS-1:0] sv, pv;
        logic [K-1:0] w;
        rst = 1; in_valid = 0; in_sys = 0; in_par = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 0;
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_busy", int'(busy), 0);

        // pin the encoder model with hand-computed pairs
        encode(16'h0001, sv, pv);
        chk("enc_sys_first4", int'(sv[3:0]), 4'b0001);
        chk("enc_par_first4", int'(pv[3:0]), 4'b0111);
        encode(16'h0000, sv, pv);
        chk("enc_zero_sys", int'(sv), 0);
        chk("enc_zero_par", int'(pv), 0);

        // all-zero block
        send_block(16'h0000, -1, 0, 0, 1);
        @(negedge clk);
        chk("trace_busy", int'(busy), 1);
        chk("trace_in_ready", int'(in_ready), 0);
        wait_done();

        // single leading one
        send_block(16'h0001, -1, 0, 0, 1);
        wait_done();

        // random word with flipped parity at step 5, then with stalls
        w = 16'($urandom);
        send_block(w, 5, 1, 0, 1);
        wait_done();
        send_block(w, 5, 1, 1, 1);
        wait_done();

        // reset after 9 accepted symbols
        encode(16'h0000, sv, pv);
        for (int t = 0; t < 9; t++) send_sym(sv[t], pv[t], 0);
        @(negedge clk);
        in_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("midrst_no_out", exp_q.size(), 0);
        send_block(16'h0000, -1, 0, 0, 1);
        wait_done();

        // back-to-back blocks; next block's first symbol stays valid through TRACE/OUT
        send_block(16'hA5C3, -1, 0, 0, 1);
        send_block(16'h0F0F, -1, 0, 0, 1);
        wait_done();

        // randomized blocks with at most one channel error and random stalls
        for (int b = 0; b < 8; b++) begin
            send_block(16'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NS - 1)) : -1,
                       1'($urandom_range(0, 1)), 2, 1);
            if ($urandom_range(0, 1) == 1) wait_done();
        end
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
